// File: rtl/mul_div_unit_pkg.sv
// Shared MDU op encodings (same codes the funct decoder emits) and FSM state codes.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MDUOP_MULT  = 3'b000,
    MDUOP_MULTU = 3'b001,
    MDUOP_DIV   = 3'b010,
    MDUOP_DIVU  = 3'b011,
    MDUOP_MTHI  = 3'b100,
    MDUOP_MTLO  = 3'b101,
    MDUOP_NOP0  = 3'b110,
    MDUOP_NOP1  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // mult/multu/div/divu all have op[2]==0; op[0] selects the unsigned flavour.
  function automatic logic op_is_iter(mdu_op_e op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic op_is_signed(mdu_op_e op);
    return (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX-stage control path and the multiply/divide unit.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring
// shift-subtract step per cycle on a single 2*WIDTH accumulator.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn_op;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  assign sgn_op = op_is_signed(bus.op);
  assign a_abs  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply: low half holds the remaining multiplier bits, high half the partial product.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: partial remainder < 2*divisor, so WIDTH+1 bits hold the sign of the trial subtract.
  assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign prod_fix = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (op_is_iter(bus.op)) begin
            acc_d     = {{WIDTH{1'b0}}, a_abs};
            opnd_d    = b_abs;
            div_d     = bus.op[1];
            neg_d     = sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rem_neg_d = sgn_op && bus.a[WIDTH-1];
            zero_d    = bus.op[1] && (bus.b == '0);
            cnt_d     = '0;
            state_d   = ST_RUN;
          end else if (bus.op == MDUOP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == MDUOP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      ST_RUN: begin
        if (div_q) begin
          if (div_diff[WIDTH]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          else                 acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (!zero_q) begin
          // most-negative / -1 falls out naturally: negating 2^(WIDTH-1) wraps to itself.
          lo_d = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything, including the FIX write and a same-cycle MTHI/MTLO.
    if (bus.flush) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table for mult/div results and latency,
// plus hand sequences for flush, MTHI/MTLO, ignored starts and async reset.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
  endtask

  // Counts busy samples (first one is the sample right after the start edge).
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done) pulses++;
      step();
    end
    chk(name, 32'(pulses), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] exp_hi, exp_lo;

    vecs[0] = '{MDUOP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{MDUOP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[2] = '{MDUOP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MDUOP_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{MDUOP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{MDUOP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6] = '{MDUOP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7] = '{MDUOP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{MDUOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[9] = '{MDUOP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    bus.start = 1'b0;
    bus.op    = MDUOP_NOP0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      chk($sformatf("vec%0d busy cycles", i), 32'(n), 32'(LAT));
      chk($sformatf("vec%0d done pulse", i), 32'(bus.done), 32'd1);
      chk($sformatf("vec%0d hi", i), bus.hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d lo", i), bus.lo, vecs[i].exp_lo);
      $display("vec %0d op=%0d a=%08h b=%08h -> hi=%08h lo=%08h busy=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus.hi, bus.lo, n);
      step();
      chk($sformatf("vec%0d done low after", i), 32'(bus.done), 32'd0);
    end
    exp_hi = 32'h40000000;
    exp_lo = 32'h00000000;

    // NOP with start: nothing moves.
    issue(MDUOP_NOP0, 32'h11111111, 32'h22222222);
    chk("nop busy", 32'(bus.busy), 32'd0);
    chk("nop hi", bus.hi, exp_hi);
    chk("nop lo", bus.lo, exp_lo);
    $display("nop -> hi=%08h lo=%08h", bus.hi, bus.lo);

    // MULT flushed in its 10th busy cycle, then an immediate MTLO.
    issue(MDUOP_MULT, 32'd5, 32'd6);
    repeat (9) step();
    chk("flush10 busy before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush10 busy after", 32'(bus.busy), 32'd0);
    chk("flush10 done", 32'(bus.done), 32'd0);
    issue(MDUOP_MTLO, 32'h12345678, 32'd0);
    exp_lo = 32'h12345678;
    chk("mtlo lo", bus.lo, exp_lo);
    chk("mtlo hi", bus.hi, exp_hi);
    chk("mtlo busy", 32'(bus.busy), 32'd0);
    watch_no_done("flush10 no late done", 40);
    chk("flush10 hi kept", bus.hi, exp_hi);
    chk("flush10 lo kept", bus.lo, exp_lo);
    $display("flush in run + mtlo -> hi=%08h lo=%08h", bus.hi, bus.lo);

    // MTHI with a simultaneous flush is suppressed.
    bus.flush = 1'b1;
    issue(MDUOP_MTHI, 32'hCAFEF00D, 32'd0);
    bus.flush = 1'b0;
    chk("mthi+flush hi", bus.hi, exp_hi);
    $display("mthi with flush -> hi=%08h", bus.hi);

    // Flush landing exactly in FIX: no write, no done.
    issue(MDUOP_MULT, 32'd5, 32'd6);
    repeat (LAT - 1) step();
    chk("fixflush busy before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fixflush busy", 32'(bus.busy), 32'd0);
    chk("fixflush done", 32'(bus.done), 32'd0);
    chk("fixflush hi", bus.hi, exp_hi);
    chk("fixflush lo", bus.lo, exp_lo);
    watch_no_done("fixflush no late done", 3);
    $display("flush in fix -> hi=%08h lo=%08h", bus.hi, bus.lo);

    // DIVU by zero with an MTHI attempted while busy: both leave HI/LO alone.
    issue(MDUOP_DIVU, 32'd51, 32'd0);
    repeat (3) step();
    issue(MDUOP_MTHI, 32'hDEADBEEF, 32'd0);
    wait_idle(n);
    chk("divu0+mthi busy cycles", 32'(n + 4), 32'(LAT));
    chk("divu0+mthi done", 32'(bus.done), 32'd1);
    chk("divu0+mthi hi", bus.hi, exp_hi);
    chk("divu0+mthi lo", bus.lo, exp_lo);
    $display("divu/0 with mthi while busy -> hi=%08h lo=%08h", bus.hi, bus.lo);
    step();

    // Async reset in the middle of a DIVU.
    issue(MDUOP_DIVU, 32'd100, 32'd3);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst hi", bus.hi, 32'd0);
    chk("midrst lo", bus.lo, 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    $display("reset mid divu -> hi=%08h lo=%08h busy=%0d", bus.hi, bus.lo, bus.busy);
    step();
    rst = 1'b0;
    step();

    issue(MDUOP_MULTU, 32'd6, 32'd7);
    wait_idle(n);
    chk("postrst busy cycles", 32'(n), 32'(LAT));
    chk("postrst hi", bus.hi, 32'd0);
    chk("postrst lo", bus.lo, 32'd42);
    $display("multu after reset -> hi=%08h lo=%08h", bus.hi, bus.lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
